// File: rtl/sgd_stream_engine.sv
// -----------------------------------------------------------------------------
// sgd_stream_engine
//
// Purpose: streaming SGD weight-update engine. One training sample arrives as
// NUM_CHUNKS chunks of SIZE lanes over a valid/ready handshake. The engine
// accumulates the fixed-point dot product x.w, computes a loss gradient
// (linear regression or SVM hinge), then replays the buffered chunks and emits
// updated weights w - mu*err*x, one chunk per cycle.
//
// Optional feature: define SGD_SATURATE_EN to make every multiply and every
// add/subtract saturate to the signed BITWIDTH range instead of wrapping.
// Timing and handshake are identical in both builds.
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   in_valid  input chunk present
//   in_ready  engine accepts a chunk (0 while rst_n is low)
//   in_x      packed activations, lane i at [BITWIDTH*i +: BITWIDTH]
//   in_w      packed current weights, same packing
//   in_y      label, sampled with the last chunk
//   mu        learning rate, sampled with the last chunk
//   mode      0 = linear regression, 1 = SVM hinge; sampled with the last chunk
//   out_valid out_w holds an updated chunk this cycle
//   out_last  final chunk of a sample
//   out_w     updated weights, same packing as in_w
//   err_out   last computed gradient scalar
//   busy      engine is mid-sample
// -----------------------------------------------------------------------------
module sgd_stream_engine #(
  parameter int BITWIDTH   = 16,
  parameter int FRAC       = 8,
  parameter int SIZE       = 4,
  parameter int NUM_CHUNKS = 2,
  parameter int LOG_CHUNKS = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BITWIDTH*SIZE-1:0]   in_x,
  input  logic [BITWIDTH*SIZE-1:0]   in_w,
  input  logic [BITWIDTH-1:0]        in_y,
  input  logic [BITWIDTH-1:0]        mu,
  input  logic                       mode,
  output logic                       out_valid,
  output logic                       out_last,
  output logic [BITWIDTH*SIZE-1:0]   out_w,
  output logic [BITWIDTH-1:0]        err_out,
  output logic                       busy
);

  localparam int BW = BITWIDTH;
  typedef logic signed [BW-1:0] data_t;
  typedef logic [BW*SIZE-1:0]   chunk_t;
  typedef enum logic [1:0] {ACCUM, ERR, UPDATE} state_t;

  localparam data_t ONE = data_t'(1 <<< FRAC);

`ifdef SGD_SATURATE_EN
  localparam logic signed [2*BW:0] SAT_MAX = {{(BW+2){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [2*BW:0] SAT_MIN = {{(BW+2){1'b1}}, {(BW-1){1'b0}}};
`endif

  // Reduce a wide intermediate to BITWIDTH: clamp or wrap depending on build.
  function automatic data_t f_sat(input logic signed [2*BW:0] v);
`ifdef SGD_SATURATE_EN
    if (v > SAT_MAX)      return data_t'(SAT_MAX[BW-1:0]);
    else if (v < SAT_MIN) return data_t'(SAT_MIN[BW-1:0]);
    else                  return data_t'(v[BW-1:0]);
`else
    return data_t'(v[BW-1:0]);
`endif
  endfunction

  // Full-width signed product, arithmetic shift by FRAC, then reduce.
  function automatic data_t f_mul(input data_t a, input data_t b);
    logic signed [2*BW-1:0] p;
    p = (2*BW)'(a) * (2*BW)'(b);
    p = p >>> FRAC;
    return f_sat({p[2*BW-1], p});
  endfunction

  function automatic data_t f_add(input data_t a, input data_t b);
    logic signed [2*BW:0] s;
    s = (2*BW+1)'(a) + (2*BW+1)'(b);
    return f_sat(s);
  endfunction

  function automatic data_t f_sub(input data_t a, input data_t b);
    logic signed [2*BW:0] s;
    s = (2*BW+1)'(a) - (2*BW+1)'(b);
    return f_sat(s);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                r_state;
  state_t                w_state_next;
  logic [LOG_CHUNKS-1:0] r_cnt;
  data_t                 r_acc;
  data_t                 r_y;
  data_t                 r_mu;
  logic                  r_mode;
  data_t                 r_g;
  data_t                 r_err;
  logic                  r_out_valid;
  logic                  r_out_last;
  chunk_t                r_out_w;

  // Sample buffer; the chunk counter doubles as write and read pointer.
  chunk_t                r_xbuf [NUM_CHUNKS];
  chunk_t                r_wbuf [NUM_CHUNKS];

  logic                  w_hs;
  logic                  w_cnt_last;
  data_t                 w_prod [SIZE];
  data_t                 w_acc_sum;
  data_t                 w_hinge;
  data_t                 w_err;
  chunk_t                w_rx;
  chunk_t                w_rw;
  chunk_t                w_upd;

  assign in_ready   = rst_n && (r_state == ACCUM);
  assign w_hs       = in_valid && in_ready;
  assign w_cnt_last = (r_cnt == LOG_CHUNKS'(NUM_CHUNKS - 1));
  assign w_rx       = r_xbuf[r_cnt];
  assign w_rw       = r_wbuf[r_cnt];

  // Per-lane products for accumulation and per-lane weight updates.
  generate
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
      assign w_prod[gi] = f_mul(data_t'(in_x[gi*BW +: BW]), data_t'(in_w[gi*BW +: BW]));
      assign w_upd[gi*BW +: BW] = f_sub(data_t'(w_rw[gi*BW +: BW]),
                                        f_mul(r_g, data_t'(w_rx[gi*BW +: BW])));
    end
  endgenerate

  // Lanes are folded into acc one at a time so that the saturating build
  // clamps at every step, like a sequential accumulator would.
  always_comb begin
    w_acc_sum = r_acc;
    for (int i = 0; i < SIZE; i++) begin
      w_acc_sum = f_add(w_acc_sum, w_prod[i]);
    end
  end

  // Gradient scalar: linear residual, or hinge (-y inside the margin, else 0).
  always_comb begin
    w_hinge = f_mul(r_y, r_acc);
    w_err   = f_sub(r_acc, r_y);
    if (r_mode) begin
      w_err = (w_hinge < ONE) ? f_sub('0, r_y) : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACCUM:   if (w_hs && w_cnt_last) w_state_next = ERR;
      ERR:     w_state_next = UPDATE;
      UPDATE:  if (w_cnt_last) w_state_next = ACCUM;
      default: w_state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_next;
  end

  // Buffer storage carries no reset; stale contents are never read because
  // UPDATE is only reached after every entry of the sample was rewritten.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_xbuf[r_cnt] <= in_x;
      r_wbuf[r_cnt] <= in_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_y         <= '0;
      r_mu        <= '0;
      r_mode      <= 1'b0;
      r_g         <= '0;
      r_err       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_w     <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      case (r_state)
        ACCUM: begin
          if (w_hs) begin
            r_acc <= w_acc_sum;
            if (w_cnt_last) begin
              r_cnt  <= '0;
              r_y    <= data_t'(in_y);
              r_mu   <= data_t'(mu);
              r_mode <= mode;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ERR: begin
          r_err <= w_err;
          r_g   <= f_mul(r_mu, w_err);
          r_acc <= '0;
        end
        UPDATE: begin
          r_out_w     <= w_upd;
          r_out_valid <= 1'b1;
          r_out_last  <= w_cnt_last;
          r_cnt       <= w_cnt_last ? '0 : r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_w     = r_out_w;
  assign err_out   = r_err;
  assign busy      = (r_state != ACCUM) || (r_cnt != '0);

endmodule

// File: tb/tb_sgd_stream_engine.sv
// -----------------------------------------------------------------------------
// tb_sgd_stream_engine: directed self-checking bench for sgd_stream_engine at
// default parameters (BITWIDTH=16, FRAC=8, SIZE=4, NUM_CHUNKS=2).
// Each sample uses a uniform lane value per chunk; expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_sgd_stream_engine;
  localparam int BW   = 16;
  localparam int SIZE = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [BW*SIZE-1:0] in_x;
  logic [BW*SIZE-1:0] in_w;
  logic [BW-1:0]      in_y;
  logic [BW-1:0]      mu;
  logic               mode;
  logic               out_valid;
  logic               out_last;
  logic [BW*SIZE-1:0] out_w;
  logic [BW-1:0]      err_out;
  logic               busy;

  sgd_stream_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_w(in_w), .in_y(in_y), .mu(mu), .mode(mode),
    .out_valid(out_valid), .out_last(out_last), .out_w(out_w),
    .err_out(err_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: output beats, handshake cycles (cycle value after the accepting
  // edge), and cycles with in_ready low while out of reset.
  logic [BW*SIZE-1:0] bq_w [$];
  logic               bq_last [$];
  int                 bq_cyc [$];
  int                 hs_q [$];
  int                 ready_low;

  always @(negedge clk) begin
    if (out_valid) begin
      bq_w.push_back(out_w);
      bq_last.push_back(out_last);
      bq_cyc.push_back(cyc);
    end
    if (in_valid && in_ready) hs_q.push_back(cyc + 1);
    if (rst_n && !in_ready) ready_low++;
  end

  function automatic logic [BW*SIZE-1:0] rep(input logic [BW-1:0] v);
    return {SIZE{v}};
  endfunction

  task automatic clear_mon();
    bq_w.delete();
    bq_last.delete();
    bq_cyc.delete();
    hs_q.delete();
    ready_low = 0;
  endtask

  // Returns at posedge+1 of the accepting edge.
  task automatic wait_hs(output bit ok);
    bit seen = 1'b0;
    for (int t = 0; t < 64 && !seen; t++) begin
      @(negedge clk);
      seen = in_ready;
      @(posedge clk);
      #1;
    end
    ok = seen;
  endtask

  task automatic send_sample(input logic [BW-1:0] xv, input logic [BW-1:0] w0,
                             input logic [BW-1:0] w1, input logic [BW-1:0] y,
                             input logic [BW-1:0] m, input logic md, input bit hold);
    bit ok;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_x     = rep(xv);
      in_w     = rep((k == 0) ? w0 : w1);
      in_y     = y;
      mu       = m;
      mode     = md;
      wait_hs(ok);
      if (!ok) begin
        n_vec++; n_err++;
        $display("FAIL handshake_timeout: chunk %0d not accepted, required accept", k);
      end
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (bq_w.size() < n && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (bq_w.size() < n) begin
      n_vec++; n_err++;
      $display("FAIL beat_timeout: got %0d beats, required %0d", bq_w.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_w = '0; in_y = '0; mu = '0; mode = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rst_out_last: got %b required 0", out_last); end
    n_vec++; if (out_w !== '0) begin n_err++; $display("FAIL rst_out_w: got %h required 0", out_w); end
    n_vec++; if (err_out !== '0) begin n_err++; $display("FAIL rst_err_out: got %h required 0", err_out); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_linear();
    clear_mon();
    send_sample(16'd256, 16'd128, 16'd128, 16'd256, 16'd26, 1'b0, 1'b0);
    wait_beats(2);
    n_vec++;
    if (bq_w.size() !== 2 || hs_q.size() !== 2) begin
      n_err++; $display("FAIL lin_counts: got beats=%0d hs=%0d required 2/2", bq_w.size(), hs_q.size());
    end else begin
      n_vec++; if (err_out !== 16'd768) begin n_err++; $display("FAIL lin_err: got %h required %h", err_out, 16'd768); end
      n_vec++; if (bq_w[0] !== rep(16'd50)) begin n_err++; $display("FAIL lin_beat0: got %h required %h", bq_w[0], rep(16'd50)); end
      n_vec++; if (bq_w[1] !== rep(16'd50)) begin n_err++; $display("FAIL lin_beat1: got %h required %h", bq_w[1], rep(16'd50)); end
      n_vec++; if (bq_last[0] !== 1'b0 || bq_last[1] !== 1'b1) begin n_err++; $display("FAIL lin_last: got %b%b required 01", bq_last[0], bq_last[1]); end
      n_vec++; if (bq_cyc[0] - hs_q[1] !== 2) begin n_err++; $display("FAIL lin_latency: got %0d required 2", bq_cyc[0] - hs_q[1]); end
      n_vec++; if (bq_cyc[1] - bq_cyc[0] !== 1) begin n_err++; $display("FAIL lin_beat_gap: got %0d required 1", bq_cyc[1] - bq_cyc[0]); end
    end
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lin_valid_drop: got %b required 0", out_valid); end
    n_vec++; if (out_w !== rep(16'd50)) begin n_err++; $display("FAIL lin_hold: got %h required %h", out_w, rep(16'd50)); end
  endtask

  task automatic test_svm_margin();
    clear_mon();
    send_sample(16'd256, 16'd128, 16'd128, 16'd256, 16'd26, 1'b1, 1'b0);
    wait_beats(2);
    n_vec++; if (err_out !== 16'd0) begin n_err++; $display("FAIL svm0_err: got %h required 0000", err_out); end
    n_vec++;
    if (bq_w.size() !== 2) begin
      n_err++; $display("FAIL svm0_count: got %0d required 2", bq_w.size());
    end else if (bq_w[0] !== rep(16'd128) || bq_w[1] !== rep(16'd128)) begin
      n_err++; $display("FAIL svm0_beats: got %h %h required %h", bq_w[0], bq_w[1], rep(16'd128));
    end
  endtask

  task automatic test_svm_hinge();
    clear_mon();
    send_sample(16'd256, 16'd0, 16'd0, 16'd256, 16'd26, 1'b1, 1'b0);
    wait_beats(2);
    n_vec++; if (err_out !== 16'hFF00) begin n_err++; $display("FAIL svm1_err: got %h required ff00", err_out); end
    n_vec++;
    if (bq_w.size() !== 2) begin
      n_err++; $display("FAIL svm1_count: got %0d required 2", bq_w.size());
    end else if (bq_w[0] !== rep(16'd26) || bq_w[1] !== rep(16'd26)) begin
      n_err++; $display("FAIL svm1_beats: got %h %h required %h", bq_w[0], bq_w[1], rep(16'd26));
    end
  endtask

  task automatic test_overflow();
    logic [BW-1:0] exp_err;
`ifdef SGD_SATURATE_EN
    exp_err = 16'h7FFF;
`else
    exp_err = 16'hF800;
`endif
    clear_mon();
    send_sample(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'd0, 16'd0, 1'b0, 1'b0);
    wait_beats(2);
    n_vec++; if (err_out !== exp_err) begin n_err++; $display("FAIL ovf_err: got %h required %h", err_out, exp_err); end
    n_vec++;
    if (bq_w.size() !== 2) begin
      n_err++; $display("FAIL ovf_count: got %0d required 2", bq_w.size());
    end else if (bq_w[1] !== rep(16'h7FFF)) begin
      n_err++; $display("FAIL ovf_beat: got %h required %h", bq_w[1], rep(16'h7FFF));
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] exp_lane [6];
    exp_lane = '{16'd50, 16'd50, 16'hFFB2, 16'h00B2, 16'd38, 16'd38};
    clear_mon();
    send_sample(16'd256, 16'd128, 16'd128, 16'd256, 16'd26, 1'b0, 1'b1);
    send_sample(16'd256, 16'd0,   16'd256, 16'd256, 16'd26, 1'b0, 1'b1);
    send_sample(16'd256, 16'd64,  16'd64,  16'd256, 16'd26, 1'b0, 1'b0);
    wait_beats(6);
    n_vec++;
    if (hs_q.size() !== 6 || bq_w.size() !== 6) begin
      n_err++; $display("FAIL b2b_counts: got hs=%0d beats=%0d required 6/6", hs_q.size(), bq_w.size());
    end else begin
      n_vec++; if (hs_q[1] - hs_q[0] !== 1) begin n_err++; $display("FAIL b2b_chunk_gap: got %0d required 1", hs_q[1] - hs_q[0]); end
      n_vec++; if (hs_q[2] - hs_q[1] !== 4) begin n_err++; $display("FAIL b2b_gap1: got %0d required 4", hs_q[2] - hs_q[1]); end
      n_vec++; if (hs_q[4] - hs_q[3] !== 4) begin n_err++; $display("FAIL b2b_gap2: got %0d required 4", hs_q[4] - hs_q[3]); end
      for (int i = 0; i < 6; i++) begin
        n_vec++;
        if (bq_w[i] !== rep(exp_lane[i]) || bq_last[i] !== logic'(i % 2)) begin
          n_err++;
          $display("FAIL b2b_beat%0d: got %h last=%b required %h last=%0d", i, bq_w[i], bq_last[i], rep(exp_lane[i]), i % 2);
        end
      end
    end
    n_vec++; if (ready_low !== 9) begin n_err++; $display("FAIL b2b_ready_low: got %0d required 9", ready_low); end
    n_vec++; if (err_out !== 16'd256) begin n_err++; $display("FAIL b2b_err: got %h required 0100", err_out); end
  endtask

  task automatic test_reset_mid_update();
    int t = 0;
    send_sample(16'd256, 16'd128, 16'd128, 16'd256, 16'd26, 1'b0, 1'b0);
    while (out_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_first_beat: got %b required 1", out_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid: got %b required 0", out_valid); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_in_ready: got %b required 0", in_ready); end
    n_vec++; if (err_out !== '0) begin n_err++; $display("FAIL mid_err_clear: got %h required 0", err_out); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    repeat (4) @(negedge clk);
    n_vec++; if (bq_w.size() !== 0) begin n_err++; $display("FAIL mid_stale: got %0d beats required 0", bq_w.size()); end
    send_sample(16'd256, 16'd128, 16'd128, 16'd256, 16'd26, 1'b0, 1'b0);
    wait_beats(2);
    n_vec++; if (err_out !== 16'd768) begin n_err++; $display("FAIL mid_fresh_err: got %h required 0300", err_out); end
    n_vec++;
    if (bq_w.size() !== 2) begin
      n_err++; $display("FAIL mid_fresh_count: got %0d required 2", bq_w.size());
    end else if (bq_w[0] !== rep(16'd50) || bq_w[1] !== rep(16'd50) || bq_last[1] !== 1'b1) begin
      n_err++; $display("FAIL mid_fresh_beats: got %h %h last=%b required %h last=1", bq_w[0], bq_w[1], bq_last[1], rep(16'd50));
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_svm_margin();
    test_svm_hinge();
    test_overflow();
    test_back_to_back();
    test_reset_mid_update();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sgd_stream_engine.md
Name: sgd_stream_engine

Overview:
- Parametrised successor to the fixed 4-lane Axiline SGD accelerator.
- Streams one training sample as NUM_CHUNKS chunks of SIZE lanes each, with a valid/ready handshake.
- Per sample: accumulates the dot product, computes a mode-selectable loss gradient, then streams out updated weights chunk by chunk.
- Sits between the x/w/label feeder and the weight write-back memory.

Parameters:
BITWIDTH, 16, signed two's-complement data width
FRAC, 8, fractional bits of fixed point (1.0 = 1<<FRAC)
SIZE, 4, lanes per chunk
NUM_CHUNKS, 2, chunks per sample (>=1)
LOG_CHUNKS, 1, counter width, = max(1, clog2(NUM_CHUNKS))

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  chunk present
in_ready  out  1  engine accepts chunk
in_x  in  BITWIDTH*SIZE  packed activations, lane i at [BITWIDTH*i +: BITWIDTH]
in_w  in  BITWIDTH*SIZE  packed current weights, same packing
in_y  in  BITWIDTH  label, sampled with last chunk
mu  in  BITWIDTH  learning rate, sampled with last chunk
mode  in  1  0 = linear regression, 1 = SVM hinge; sampled with last chunk
out_valid  out  1  out_w holds an updated chunk
out_last  out  1  final chunk of a sample
out_w  out  BITWIDTH*SIZE  updated weights, same packing
err_out  out  BITWIDTH  last computed gradient scalar
busy  out  1  not in ACCUM, or chunk count nonzero

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset (async assert): state=ACCUM, chunk_cnt=0, acc=0, buffer pointers=0, out_valid=0, out_last=0, out_w=0, err_out=0. in_ready is forced 0 while rst_n=0.
- Fixed-point multiply: full 2*BITWIDTH signed product, arithmetic shift right by FRAC, then truncate to BITWIDTH (wrap). Add/subtract wraps at BITWIDTH.
- ACCUM:
  - in_ready=1.
  - On handshake: acc += sum over lanes of mul(x_i, w_i); chunk written to internal x/w buffer (depth NUM_CHUNKS); chunk_cnt++.
  - On the handshake with chunk_cnt==NUM_CHUNKS-1: latch y, mu, mode; go to ERR; chunk_cnt=0.
- ERR (1 cycle):
  - in_ready=0.
  - err = acc-y when mode=0.
  - When mode=1: err = -y if mul(y,acc) < (1<<FRAC), else 0.
  - err_out<=err; g<=mul(mu,err); acc<=0; go to UPDATE.
- UPDATE:
  - in_ready=0.
  - Each cycle reads buffer entry k, k=0..NUM_CHUNKS-1, in arrival order.
  - Registers out_w lane i = w_i - mul(g, x_i); out_valid=1; out_last=(k==NUM_CHUNKS-1).
  - After the last entry, return to ACCUM.
  - No output backpressure; consumer must take every out_valid beat.
- Latency:
  - First out_w beat is valid 2 cycles after the handshake of the last input chunk.
  - Sample period is 2*NUM_CHUNKS+1 cycles minimum.
- out_valid/out_last are 0 in every cycle not emitting a beat; out_w holds its last value.
- err_out holds until the next ERR.
- in_valid while in_ready=0 is ignored; in_x/in_w need not be held.
- NUM_CHUNKS=1: ACCUM→ERR→UPDATE, one output beat with out_last=1.
- rst_n asserted mid-sample or mid-UPDATE: partial accumulation and remaining beats are discarded; no further out_valid until a new full sample.

Optional Feature:
- Macro: SGD_SATURATE_EN.
- When defined: every mul result and every add/subtract, including the acc accumulation and the err/out_w subtractions, saturates to [-(2^(BITWIDTH-1)), 2^(BITWIDTH-1)-1] instead of wrapping.
- When undefined: pure wrap arithmetic as above.
- Timing and handshake are identical either way.

Test Plan:
- Default params, mode=0, all x=256, all w=128, y=256, mu=26, two chunks back to back → err_out=768; two beats out_w lanes all 50; out_last on 2nd beat; first beat 2 cycles after the last handshake.
- Same stimulus, mode=1 → err_out=0; out_w lanes all 128.
- mode=1, w=0, x=256, y=256, mu=26 → err_out=-256 (0xFF00); out_w lanes all 26.
- All x=w=0x7FFF, y=0, mode=0:
  - without SGD_SATURATE_EN → err_out=-2048 (0xF800);
  - with SGD_SATURATE_EN → err_out=32767.
- in_valid held high continuously for 3 samples → in_ready low for exactly NUM_CHUNKS+1 cycles after each last chunk; no chunk lost or duplicated; 6 output beats in order.
- Assert rst_n low during 1st UPDATE beat, release, then send a fresh sample → out_valid drops asynchronously; no stale beat; fresh sample's results match the single-sample reference values.
